// File: rtl/peridot_spi_flashreader.sv
// Serial-flash read sequencer driving the SPI master CSR block over Avalon-MM.
// Sends opcode, 24-bit address and dummy bytes, then streams N received data bytes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready=1
// S_CFG   | reg01 configuration write in flight, header sequence loaded
// S_START | reg00 write launching one SPI byte (start=1, select=1)
// S_POLL  | reading reg00 every cycle until the ready bit (bit9) is set
// S_OUT   | data byte presented on the output stream, waiting for out_ready
// S_DESEL | reg00 write dropping select
// S_DONE  | one-cycle completion pulse, cmd_ready=1 again
module peridot_spi_flashreader #(
    parameter logic [7:0] READ_OPCODE = 8'h03,
    parameter int         DUMMY_BYTES = 0,
    parameter logic [1:0] CFG_MODE    = 2'd0,
    parameter logic [7:0] CFG_CLKDIV  = 8'd1
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_addr,
    input  logic [15:0] cmd_length,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        done,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata
);

    localparam logic [2:0]  HDR_LEN    = 3'(4 + DUMMY_BYTES);
    localparam logic [31:0] REG01_WORD = {16'h0000, 1'b0, 1'b0, CFG_MODE, 4'h0, CFG_CLKDIV};

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_START, S_POLL, S_OUT, S_DESEL, S_DONE
    } state_t;

    state_t      state;
    logic [23:0] addr_q;
    logic [15:0] remaining;
    logic [2:0]  hdr_idx;
    logic        in_data;
    logic [2:0]  hdr_next;
    logic        unused_rd;

    assign hdr_next  = hdr_idx + 3'd1;
    assign unused_rd = ^{avm_readdata[31:10], avm_readdata[8]};

    function automatic logic [31:0] reg00_word(input logic start, input logic sel,
                                               input logic [7:0] tx);
        return {16'h0000, 1'b0, 5'h00, start, sel, tx};
    endfunction

    // Header byte order: opcode, address MSB first, then dummy zeros.
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [23:0] a);
        logic [7:0] b;
        case (idx)
            3'd0:    b = READ_OPCODE;
            3'd1:    b = a[23:16];
            3'd2:    b = a[15:8];
            3'd3:    b = a[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state         <= S_IDLE;
            cmd_ready     <= 1'b1;
            out_valid     <= 1'b0;
            out_data      <= 8'h00;
            busy          <= 1'b0;
            done          <= 1'b0;
            avm_address   <= 1'b0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= 32'h0;
            addr_q        <= 24'h0;
            remaining     <= 16'h0;
            hdr_idx       <= 3'd0;
            in_data       <= 1'b0;
        end else begin
            avm_write   <= 1'b0;
            avm_address <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (cmd_valid) begin
                        addr_q        <= cmd_addr;
                        remaining     <= cmd_length;
                        hdr_idx       <= 3'd0;
                        in_data       <= 1'b0;
                        cmd_ready     <= 1'b0;
                        busy          <= 1'b1;
                        avm_write     <= 1'b1;
                        avm_address   <= 1'b1;
                        avm_writedata <= REG01_WORD;
                        state         <= S_CFG;
                    end
                end
                S_CFG: begin
                    avm_write     <= 1'b1;
                    avm_writedata <= reg00_word(1'b1, 1'b1, hdr_byte(3'd0, addr_q));
                    state         <= S_START;
                end
                S_START: begin
                    avm_read <= 1'b1;
                    state    <= S_POLL;
                end
                S_POLL: begin
                    if (avm_readdata[9]) begin
                        avm_read <= 1'b0;
                        if (in_data) begin
                            out_data  <= avm_readdata[7:0];
                            out_valid <= 1'b1;
                            state     <= S_OUT;
                        end else if (hdr_next < HDR_LEN) begin
                            hdr_idx       <= hdr_next;
                            avm_write     <= 1'b1;
                            avm_writedata <= reg00_word(1'b1, 1'b1, hdr_byte(hdr_next, addr_q));
                            state         <= S_START;
                        end else if (remaining != 16'd0) begin
                            in_data       <= 1'b1;
                            avm_write     <= 1'b1;
                            avm_writedata <= reg00_word(1'b1, 1'b1, 8'h00);
                            state         <= S_START;
                        end else begin
                            avm_write     <= 1'b1;
                            avm_writedata <= reg00_word(1'b0, 1'b0, 8'h00);
                            state         <= S_DESEL;
                        end
                    end
                end
                S_OUT: begin
                    // The next SPI byte only starts once the consumer has taken this one.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - 16'd1;
                        avm_write <= 1'b1;
                        if (remaining != 16'd1) begin
                            avm_writedata <= reg00_word(1'b1, 1'b1, 8'h00);
                            state         <= S_START;
                        end else begin
                            avm_writedata <= reg00_word(1'b0, 1'b0, 8'h00);
                            state         <= S_DESEL;
                        end
                    end
                end
                S_DESEL: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peridot_spi_flashreader.sv
// Bench for peridot_spi_flashreader: two instances (plain read, fast read with one
// dummy byte) share a behavioural CSR model; writes and output bytes are scoreboarded.
`timescale 1ns/1ps
module tb_peridot_spi_flashreader;

    logic        csi_clk = 1'b0;
    logic        rsi_reset = 1'b1;
    logic [1:0]  cmd_valid_v = 2'b00;
    logic [1:0]  cmd_ready_v, out_valid_v, busy_v, done_v;
    logic [1:0]  avm_address_v, avm_read_v, avm_write_v;
    logic [7:0]  out_data_v [2];
    logic [31:0] avm_writedata_v [2];
    logic [23:0] cmd_addr = 24'h0;
    logic [15:0] cmd_length = 16'h0;
    logic        out_ready = 1'b1;
    logic [31:0] avm_readdata;

    always #5 csi_clk = ~csi_clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        peridot_spi_flashreader #(
            .READ_OPCODE ((g == 1) ? 8'h0B : 8'h03),
            .DUMMY_BYTES (g),
            .CFG_MODE    (2'd0),
            .CFG_CLKDIV  (8'd1)
        ) dut (
            .csi_clk       (csi_clk),
            .rsi_reset     (rsi_reset),
            .cmd_valid     (cmd_valid_v[g]),
            .cmd_ready     (cmd_ready_v[g]),
            .cmd_addr      (cmd_addr),
            .cmd_length    (cmd_length),
            .out_valid     (out_valid_v[g]),
            .out_ready     (out_ready),
            .out_data      (out_data_v[g]),
            .busy          (busy_v[g]),
            .done          (done_v[g]),
            .avm_address   (avm_address_v[g]),
            .avm_read      (avm_read_v[g]),
            .avm_readdata  (avm_readdata),
            .avm_write     (avm_write_v[g]),
            .avm_writedata (avm_writedata_v[g])
        );
    end

    int          sel = 0;
    logic        m_read, m_write, m_address, m_out_valid;
    logic [31:0] m_wdata;
    logic [7:0]  m_out_data;
    assign m_read      = avm_read_v[sel];
    assign m_write     = avm_write_v[sel];
    assign m_address   = avm_address_v[sel];
    assign m_wdata     = avm_writedata_v[sel];
    assign m_out_valid = out_valid_v[sel];
    assign m_out_data  = out_data_v[sel];

    // CSR model state: ready bit drops on a start write and returns 4 cycles later.
    logic        csr_rdy = 1'b1;
    logic [7:0]  csr_rx = 8'h00;
    int          csr_cnt = 0;
    assign avm_readdata = {22'h0, csr_rdy, 1'b0, csr_rx};

    logic [32:0] exp_wr[$];
    logic [7:0]  exp_out[$];
    logic [7:0]  rx_q[$];
    int n_checks = 0, n_errors = 0;
    int wr_count = 0, rd_count = 0, ov_count = 0;
    int t, wbase, ov_base;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [32:0] ew;
        logic [7:0]  eo;
        forever begin
            @(negedge csi_clk);
            if (rsi_reset) begin
                csr_rdy = 1'b1;
                csr_cnt = 0;
                csr_rx  = 8'h00;
            end else begin
                if (m_read || m_write) check_val("strobe_excl", 64'(m_read & m_write), 0);
                if (m_read) rd_count++;
                if (m_write) begin
                    wr_count++;
                    check_val("wr_while_outv", 64'(m_out_valid), 0);
                    check_val("wr_expected", 64'(exp_wr.size() > 0), 1);
                    if (exp_wr.size() > 0) begin
                        ew = exp_wr.pop_front();
                        check_val("wr_word", 64'({m_address, m_wdata}), 64'(ew));
                    end
                    if (!m_address && m_wdata[9]) begin
                        csr_rdy = 1'b0;
                        csr_cnt = 4;
                        csr_rx  = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
                    end
                end else if (csr_cnt > 0) begin
                    csr_cnt--;
                    if (csr_cnt == 0) csr_rdy = 1'b1;
                end
                if (m_out_valid) ov_count++;
                if (m_out_valid && out_ready) begin
                    check_val("out_expected", 64'(exp_out.size() > 0), 1);
                    if (exp_out.size() > 0) begin
                        eo = exp_out.pop_front();
                        check_val("out_byte", 64'(m_out_data), 64'(eo));
                    end
                end
            end
        end
    endtask

    task automatic issue_cmd(input int s, input logic [23:0] a, input logic [15:0] len,
                             input logic [7:0] op, input int nd,
                             input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] hb, db;
        exp_wr.push_back({1'b1, 32'h0000_0001});
        for (int i = 0; i < 4 + nd; i++) begin
            case (i)
                0:       hb = op;
                1:       hb = a[23:16];
                2:       hb = a[15:8];
                3:       hb = a[7:0];
                default: hb = 8'h00;
            endcase
            exp_wr.push_back({1'b0, 22'h0, 2'b11, hb});
            rx_q.push_back(8'hE0 + 8'(i));
        end
        for (int i = 0; i < int'(len); i++) begin
            db = (i == 0) ? d0 : (i == 1) ? d1 : 8'(d1 + 8'(i));
            exp_wr.push_back({1'b0, 22'h0, 2'b11, 8'h00});
            rx_q.push_back(db);
            exp_out.push_back(db);
        end
        exp_wr.push_back({1'b0, 32'h0000_0000});
        @(posedge csi_clk); #1;
        check_val("cmd_ready_idle", 64'(cmd_ready_v[s]), 1);
        cmd_addr       = a;
        cmd_length     = len;
        cmd_valid_v[s] = 1'b1;
        @(posedge csi_clk); #1;
        cmd_valid_v[s] = 1'b0;
        check_val("busy_after_acc", 64'(busy_v[s]), 1);
        check_val("cmd_ready_busy", 64'(cmd_ready_v[s]), 0);
    endtask

    task automatic finish_cmd(input int s);
        int   tt;
        logic prev_busy;
        tt = 0;
        @(negedge csi_clk);
        prev_busy = busy_v[s];
        while (!done_v[s] && tt < 3000) begin
            prev_busy = busy_v[s];
            @(negedge csi_clk);
            tt++;
        end
        check_val("done_seen", 64'(tt < 3000), 1);
        if (tt < 3000) begin
            check_val("busy_in_desel", 64'(prev_busy), 1);
            check_val("busy_at_done", 64'(busy_v[s]), 0);
            check_val("ready_at_done", 64'(cmd_ready_v[s]), 1);
        end
        @(negedge csi_clk);
        check_val("done_one_cycle", 64'(done_v[s]), 0);
        repeat (3) @(negedge csi_clk);
        check_val("wr_q_drained", 64'(exp_wr.size()), 0);
        check_val("out_q_drained", 64'(exp_out.size()), 0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        repeat (3) @(posedge csi_clk);
        #1 rsi_reset = 1'b0;

        // Idle after reset
        repeat (10) @(posedge csi_clk);
        #1;
        check_val("idle_cmd_ready", 64'(cmd_ready_v), 64'(2'b11));
        check_val("idle_out_valid", 64'(out_valid_v), 0);
        check_val("idle_busy", 64'(busy_v), 0);
        check_val("idle_writes", 64'(wr_count), 0);
        check_val("idle_reads", 64'(rd_count), 0);

        // Two-byte read, plus a command attempt while busy
        sel = 0;
        issue_cmd(0, 24'h123456, 16'd2, 8'h03, 0, 8'hA5, 8'h3C);
        repeat (5) @(posedge csi_clk);
        #1;
        cmd_valid_v[0] = 1'b1;
        check_val("busy_cmd_ready", 64'(cmd_ready_v[0]), 0);
        @(posedge csi_clk); #1;
        cmd_valid_v[0] = 1'b0;
        finish_cmd(0);

        // Header only
        ov_base = ov_count;
        issue_cmd(0, 24'hFEDCBA, 16'd0, 8'h03, 0, 8'h00, 8'h00);
        finish_cmd(0);
        check_val("len0_no_out", 64'(ov_count - ov_base), 0);

        // Fast read with one dummy byte
        sel = 1;
        issue_cmd(1, 24'h0A0B0C, 16'd1, 8'h0B, 1, 8'h5A, 8'h00);
        finish_cmd(1);

        // Back-pressure on the first data byte
        sel = 0;
        out_ready = 1'b0;
        issue_cmd(0, 24'hABCDEF, 16'd2, 8'h03, 0, 8'hC3, 8'h96);
        t = 0;
        while (!m_out_valid && t < 3000) begin
            @(negedge csi_clk);
            t++;
        end
        check_val("stall_valid_seen", 64'(t < 3000), 1);
        wbase = wr_count;
        repeat (20) begin
            @(negedge csi_clk);
            check_val("stall_data", 64'(m_out_data), 64'h00C3);
        end
        check_val("stall_no_write", 64'(wr_count - wbase), 0);
        @(posedge csi_clk); #1;
        out_ready = 1'b1;
        finish_cmd(0);

        // Reset while polling the second address byte
        wbase = wr_count;
        issue_cmd(0, 24'h123456, 16'd2, 8'h03, 0, 8'h11, 8'h22);
        t = 0;
        while (wr_count < wbase + 4 && t < 3000) begin
            @(negedge csi_clk);
            t++;
        end
        check_val("rst_reach_poll", 64'(t < 3000), 1);
        repeat (2) @(posedge csi_clk);
        #1 rsi_reset = 1'b1;
        @(posedge csi_clk); #1;
        check_val("rst_outputs",
                  64'({cmd_ready_v[0], out_valid_v[0], out_data_v[0], busy_v[0], done_v[0],
                       avm_read_v[0], avm_write_v[0], avm_address_v[0], avm_writedata_v[0]}),
                  64'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
        exp_wr.delete();
        exp_out.delete();
        rx_q.delete();
        rsi_reset = 1'b0;
        issue_cmd(0, 24'h00FF01, 16'd3, 8'h03, 0, 8'h81, 8'h7E);
        finish_cmd(0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/peridot_spi_flashreader.md
Name: peridot_spi_flashreader

Overview:
- Avalon-MM master sequencer sitting directly upstream of the host-bridge SPI master CSR block (reg00 control/data, reg01 config).
- Accepts a read command (24-bit flash address, byte length) and performs a full serial-flash read through the CSR block's registers: opcode, address, optional dummy bytes, then N data bytes.
- Received bytes leave on a valid/ready byte stream. Used for boot and config loading without a CPU.

Parameters:
- READ_OPCODE, 8'h03, opcode sent first (8'h0B for fast read).
- DUMMY_BYTES, 0, 0-3; number of 8'h00 bytes sent after the address, rx discarded.
- CFG_MODE, 0, 0-3; written to reg01 bit13-12.
- CFG_CLKDIV, 1, 0-255; written to reg01 bit7-0.

Ports:
- csi_clk  in  1  clock
- rsi_reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_addr  in  24  flash byte address
- cmd_length  in  16  data bytes to read (0 allowed)
- out_valid  out  1  data byte valid
- out_ready  in  1  consumer accepts byte
- out_data  out  8  data byte, first received bit = MSB
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- avm_address  out  1  CSR register select (0=reg00, 1=reg01)
- avm_read  out  1  CSR read strobe; readdata sampled in the same cycle
- avm_readdata  in  32  CSR read data
- avm_write  out  1  CSR write strobe, single cycle
- avm_writedata  out  32  CSR write data

Behaviour:
- Clock csi_clk; rsi_reset synchronous, active-high.
- Reset values: cmd_ready=1, out_valid=0, out_data=0, busy=0, done=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0. FSM returns to IDLE and counters clear.
- Reset mid-command abandons the command with no deselect write. The CSR block shares rsi_reset, so its select is cleared by its own reset.
- Only one of avm_read/avm_write is asserted in any cycle. Each strobe lasts exactly one cycle.
- reg00 write format: bit15 irqena=0, bit9 start, bit8 select, bit7-0 txdata.
- reg01 write format: bit15 bitrvs=0, bit13-12 CFG_MODE, bit7-0 CFG_CLKDIV.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - latch addr and length; cmd_ready=0, busy=1; go CFG.
- CFG: one write to reg01, then load the tx sequence: READ_OPCODE, addr[23:16], addr[15:8], addr[7:0], then DUMMY_BYTES x 8'h00. Go START.
- START: write reg00 with start=1, select=1, txdata=current byte. Go POLL the next cycle.
- POLL:
  - Read reg00 every cycle, starting the cycle after the START write (the ready bit is 0 by then).
  - Stay in POLL while readdata[9]=0.
  - On readdata[9]=1:
    - header byte (opcode/addr/dummy): discard rx; advance header index. Next header byte -> START. Header done and length>0 -> START with txdata 8'h00. Header done and length=0 -> DESEL.
    - data byte: capture readdata[7:0] into out_data, set out_valid=1, go OUT.
- OUT: hold out_data/out_valid until out_ready.
  - On handshake: out_valid=0; decrement remaining count.
  - Remaining >0 -> START with 8'h00; remaining =0 -> DESEL.
  - The next SPI byte is never started before the current byte is accepted. out_ready high in the capture cycle still costs one OUT cycle.
- DESEL: write reg00 with start=0, select=0, txdata=0. Go DONE.
- DONE: done=1 for one cycle, busy=0, cmd_ready=1; go IDLE.
- cmd_length is 16-bit unsigned. 65535 is the maximum, and 0 means header only. The remaining count never wraps.
- cmd_valid while busy is ignored (cmd_ready=0).
- busy is 1 from the cycle after acceptance through the DESEL cycle.

Test Plan:
- Reset, then idle 10 cycles -> cmd_ready=1, no avm strobes, out_valid=0.
- cmd addr=24'h123456, length=2, DUMMY_BYTES=0; CSR model with 4-cycle ready latency, rx bytes A5,3C ->
  - reg01 write 16'h0001;
  - reg00 writes 0x303, 0x312, 0x334, 0x356, 0x300, 0x300, then 0x000;
  - out stream A5, 3C; single done pulse.
- length=0 -> four header START writes, then deselect write 0x000 and done; out_valid never asserted.
- DUMMY_BYTES=1, READ_OPCODE=0B, length=1 -> five header bytes (0B, addr x3, 00) precede the data byte; dummy rx never appears on out_data.
- out_ready held low 20 cycles after the first data byte -> out_data stable, no START write until the handshake.
- Assert rsi_reset during POLL of the 2nd address byte -> next cycle all outputs at reset values; a new command afterwards completes normally.
